// File: rtl/md_unit.sv
// md_unit: multicycle multiply/divide unit with architectural HI/LO registers.
// Operands are captured on acceptance; the result commits after a fixed latency.
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, hi_r, hi_n, lo_r, lo_n;
    logic             sgn_q, sgn_n, done_r, done_n, fin;
    logic [2*WIDTH-1:0] prod;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    assign busy = state != IDLE;
    assign done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;
    assign fin  = cnt == (state == MUL ? CW'(MUL_LAT) : CW'(DIV_LAT));

    // Sign-extending for signed ops makes one 2W-bit multiply serve both MULT and MULTU.
    assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};

    // Signed divide via magnitudes; the -2^(W-1)/-1 case wraps to the required result naturally.
    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign b_div = b_mag == '0 ? WIDTH'(1) : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        sgn_n   = sgn_q;
        hi_n    = hi_r;
        lo_n    = lo_r;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                case (op)
                    3'd1, 3'd2: begin
                        state_n = MUL;
                        cnt_n   = CW'(1);
                        a_n     = A;
                        b_n     = B;
                        sgn_n   = op == 3'd1;
                    end
                    3'd3, 3'd4: begin
                        state_n = DIV;
                        cnt_n   = CW'(1);
                        a_n     = A;
                        b_n     = B;
                        sgn_n   = op == 3'd3;
                    end
                    3'd5:    hi_n = A;
                    3'd6:    lo_n = A;
                    default: ;
                endcase
            end
        end else if (fin) begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
            if (state == MUL) begin
                hi_n = prod[2*WIDTH-1:WIDTH];
                lo_n = prod[WIDTH-1:0];
            end else if (b_q != '0) begin
                hi_n = rem;
                lo_n = quo;
            end
        end else begin
            cnt_n = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            a_q    <= a_n;
            b_q    <= b_n;
            sgn_q  <= sgn_n;
            hi_r   <= hi_n;
            lo_r   <= lo_n;
            done_r <= done_n;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; results, latency, busy and HI/LO hold
// are checked against a plain-arithmetic model of the multiply/divide rules.
module tb_md_unit;
    localparam int W = 32, ML = 5, DL = 10;

    logic         clk = 0, reset = 1, start = 0;
    logic [2:0]   op = 0;
    logic [W-1:0] A = 0, B = 0;
    logic         busy, done;
    logic [W-1:0] HI, LO;

    md_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi, lo;
        int e0, lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] vis_hi = 0, vis_lo = 0;
    int           cyc = 0, n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void compute(input logic [2:0] o, input logic [W-1:0] a, b, h0, l0,
                                    output logic [W-1:0] h, output logic [W-1:0] l);
        longint p;
        h = h0;
        l = l0;
        case (o)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p;
            end
            3'd2: {h, l} = {32'b0, a} * {32'b0, b};
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = a;
                    h = 0;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            3'd4: if (b != 0) begin
                l = a / b;
                h = a % b;
            end
            default: ;
        endcase
    endfunction

    // Monitor: pops on done, and every cycle checks busy and visible HI/LO.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) check("spurious_done", done, 0);
                else begin
                    e = sb.pop_front();
                    check("result_hi", HI, e.hi);
                    check("result_lo", LO, e.lo);
                    check("latency", cyc - e.e0, e.lat);
                    vis_hi = e.hi;
                    vis_lo = e.lo;
                end
            end
            check("busy", busy, sb.size() != 0);
            check("hi_hold", HI, vis_hi);
            check("lo_hold", LO, vis_lo);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b, input bit noise);
        exp_t e;
        wait_idle();
        start = 1;
        op = o;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 0;
        op = 3'($urandom);
        A = $urandom;
        B = $urandom;
        if (o >= 1 && o <= 4) begin
            e.lat = o <= 2 ? ML : DL;
            e.e0 = cyc;
            compute(o, a, b, vis_hi, vis_lo, e.hi, e.lo);
            sb.push_back(e);
            if (noise) begin
                repeat (e.lat - 1) begin
                    @(negedge clk);
                    start = 1;
                    op = 3'($urandom_range(1, 6));
                    A = $urandom;
                    B = $urandom;
                end
                @(negedge clk);
                start = 0;
            end
        end else begin
            if (o == 5) vis_hi = a;
            if (o == 6) vis_lo = a;
            check("mt_hi", HI, vis_hi);
            check("mt_lo", LO, vis_lo);
            check("mt_busy", busy, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        start = 1;
        op = 3'd5;
        A = $urandom;
        @(posedge clk);
        #1;
        reset = 0;
        start = 0;
        sb.delete();
        vis_hi = 0;
        vis_lo = 0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
    endtask

    task automatic expect_hl(input string name, input logic [W-1:0] h, l);
        wait_idle();
        check({name, "_hi"}, HI, h);
        check({name, "_lo"}, LO, l);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        do_reset();
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        expect_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        expect_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        expect_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        expect_hl("div_ovf", 32'h0, 32'h8000_0000);
        do_reset();
        issue(3'd5, 32'h1234_5678, 0, 0);
        check("mthi_direct", HI, 32'h1234_5678);
        issue(3'd3, 32'd100, 32'd7, 1);
        expect_hl("div_noise", 32'd2, 32'd14);
        issue(3'd5, 32'd5, 0, 0);
        issue(3'd6, 32'd6, 0, 0);
        issue(3'd4, 32'd100, 32'd0, 0);
        expect_hl("divu_zero", 32'd5, 32'd6);
        issue(3'd0, 32'hDEAD_BEEF, 1, 0);
        issue(3'd7, 32'hDEAD_BEEF, 1, 0);
        expect_hl("none_rsvd", 32'd5, 32'd6);
        issue(3'd1, 32'd7, 32'd9, 0);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        issue(3'd1, 32'd7, 32'd9, 0);
        expect_hl("post_rst_mult", 32'd0, 32'd63);
        for (int i = 0; i < 300; i++)
            issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
        wait_idle();
        repeat (2) @(negedge clk);
        check("drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
